lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 35 +++
 rtl/lsu.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// Bundle between the execute stage, the data memory port and the writeback port of the lsu.
// The slave modport is the lsu's view of the bundle; the master modport is the view of whatever drives it.
interface lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;

    modport slave (
        input  in_valid, is_load, is_store, funct3, addr, wdata, rd, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output wb_valid, wb_rd, wb_data, misaligned
    );

    modport master (
        output in_valid, is_load, is_store, funct3, addr, wdata, rd, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  wb_valid, wb_rd, wb_data, misaligned
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding memory op, IDLE -> REQ -> (RESP) -> IDLE.
// LSU_MISALIGN_TRAP_EN: misaligned ops raise a one-cycle misaligned pulse instead of being force-aligned.
module lsu (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  io_bus
);
    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e      r_state, w_state_next;
    logic        r_we;
    logic [31:0] r_addr, r_wdata, r_wb_data;
    logic [3:0]  r_wstrb;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;

    logic        w_accept, w_f3_ok, w_legal, w_misal, w_issue, w_trap;
    logic [31:0] w_align_addr, w_st_wdata, w_ld_data;
    logic [3:0]  w_st_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Decode and store-data formatting for the op offered in IDLE.
    always_comb begin
        w_accept = io_bus.in_valid && (r_state == StIdle);
        w_f3_ok  = io_bus.is_load ? (io_bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                  : (io_bus.funct3 inside {3'b000, 3'b001, 3'b010});
        w_legal  = (io_bus.is_load ^ io_bus.is_store) && w_f3_ok;
        w_misal  = ((io_bus.funct3[1:0] == 2'b01) && io_bus.addr[0]) ||
                   ((io_bus.funct3[1:0] == 2'b10) && (io_bus.addr[1:0] != 2'b00));
        case (io_bus.funct3[1:0])
            2'b01:   w_align_addr = {io_bus.addr[31:1], 1'b0};
            2'b10:   w_align_addr = {io_bus.addr[31:2], 2'b00};
            default: w_align_addr = io_bus.addr;
        endcase
        case (io_bus.funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{io_bus.wdata[7:0]}};
                w_st_wstrb = 4'b0001 << w_align_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{io_bus.wdata[15:0]}};
                w_st_wstrb = 4'b0011 << w_align_addr[1:0];
            end
            default: begin
                w_st_wdata = io_bus.wdata;
                w_st_wstrb = 4'b1111;
            end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        w_issue = w_accept && w_legal && !w_misal;
        w_trap  = w_accept && w_legal && w_misal;
`else
        w_issue = w_accept && w_legal;
        w_trap  = 1'b0;
`endif
    end

    // Load lane extraction from the returning word.
    always_comb begin
        w_byte = io_bus.mem_rdata[8*r_lane +: 8];
        w_half = r_lane[1] ? io_bus.mem_rdata[31:16] : io_bus.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'b0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'b0, w_half};
            default: w_ld_data = io_bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_issue) w_state_next = StReq;
            StReq:   if (io_bus.mem_ack) w_state_next = r_we ? StIdle : StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_lane    <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_we     <= io_bus.is_store;
                r_addr   <= {w_align_addr[31:2], 2'b00};
                r_wdata  <= io_bus.is_store ? w_st_wdata : 32'b0;
                r_wstrb  <= io_bus.is_store ? w_st_wstrb : 4'b0000;
                r_rd     <= io_bus.rd;
                r_funct3 <= io_bus.funct3;
                r_lane   <= w_align_addr[1:0];
            end
            if ((r_state == StReq) && io_bus.mem_ack && !r_we) r_wb_data <= w_ld_data;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misaligned;
    always_ff @(posedge clk) begin
        if (rst) r_misaligned <= 1'b0;
        else     r_misaligned <= w_trap;
    end
    assign io_bus.misaligned = r_misaligned;
`else
    assign io_bus.misaligned = w_trap;
`endif

    // Bus outputs are zeroed outside their owning state so reset/idle values are clean.
    assign io_bus.in_ready  = (r_state == StIdle);
    assign io_bus.mem_req   = (r_state == StReq);
    assign io_bus.mem_we    = (r_state == StReq) && r_we;
    assign io_bus.mem_addr  = (r_state == StReq) ? r_addr : 32'b0;
    assign io_bus.mem_wdata = (r_state == StReq) ? r_wdata : 32'b0;
    assign io_bus.mem_wstrb = (r_state == StReq) ? r_wstrb : 4'b0000;
    assign io_bus.wb_valid  = (r_state == StResp) && (r_rd != 5'd0);
    assign io_bus.wb_rd     = (r_state == StResp) ? r_rd : 5'd0;
    assign io_bus.wb_data   = (r_state == StResp) ? r_wb_data : 32'b0;
endmodule
